// File: rtl/upower_pkg.sv
// Shared encodings for the uPower multi-cycle sequencer: FSM states, trap causes, branch opcodes.
package upower_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        TC_NONE    = 2'd0,
        TC_ILLEGAL = 2'd1,
        TC_IMEM_TO = 2'd2,
        TC_DMEM_TO = 2'd3
    } trap_cause_t;

    localparam logic [5:0] OP_B  = 6'd18;
    localparam logic [5:0] OP_BC = 6'd19;
    localparam logic [5:0] OP_XO = 6'd31;

    // Unconditional b always redirects; bc redirects only when the condition holds.
    function automatic logic branch_taken(input logic [5:0] op, input logic cond);
        return (op == OP_B) || ((op == OP_BC) && cond);
    endfunction

endpackage

// File: rtl/upower_wait_timer.sv
// Handshake wait counter shared by FETCH and MEM; expires after LIMIT waiting cycles.
module upower_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] r_cnt;

    assign o_expired = (r_cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         r_cnt <= '0;
        else if (i_clr)                  r_cnt <= '0;
        else if (i_en && !o_expired)     r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/upower_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: drives PC/IR/regfile enables and memory handshakes.
module upower_multicycle_sequencer
    import upower_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             reg_read,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             branch,
    input  logic             cond_taken,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_load,
    output logic             pc_load,
    output logic             pc_sel,
    output logic             reg_we,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);
    state_t            r_state, w_next;
    trap_cause_t       r_cause, w_cause;
    logic [CNT_W-1:0]  r_retired;
    logic              w_expired, w_retire, w_mem_op;

    assign w_mem_op = mem_read | mem_write;

    // Any state change restarts the wait window, so MEM->FETCH gets a fresh budget.
    upower_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_next != r_state),
        .i_en      ((r_state == ST_FETCH) || (r_state == ST_MEM)),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cause   <= TC_NONE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ST_TRAP && r_state != ST_TRAP) r_cause <= w_cause;
            if (w_retire) r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_cause = TC_NONE;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)       w_next = ST_DECODE;
                else if (w_expired) begin w_next = ST_TRAP; w_cause = TC_IMEM_TO; end
            end
            ST_DECODE: begin
                if (reg_read | reg_write | w_mem_op | branch) w_next = ST_EXEC;
                else begin w_next = ST_TRAP; w_cause = TC_ILLEGAL; end
            end
            ST_EXEC: begin
                if (branch)         w_next = ST_FETCH;
                else if (w_mem_op)  w_next = ST_MEM;
                else if (reg_write) w_next = ST_WB;
                else                w_next = ST_FETCH;
            end
            ST_MEM: begin
                if (dmem_ack)       w_next = reg_write ? ST_WB : ST_FETCH;
                else if (w_expired) begin w_next = ST_TRAP; w_cause = TC_DMEM_TO; end
            end
            ST_WB:     w_next = ST_FETCH;
            ST_TRAP:   w_next = ST_TRAP;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_load  = 1'b0;
        pc_sel   = 1'b0;
        reg_we   = 1'b0;
        w_retire = 1'b0;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            ST_EXEC: begin
                if (branch) begin
                    pc_load  = 1'b1;
                    pc_sel   = branch_taken(opcode, cond_taken);
                    w_retire = 1'b1;
                end else if (!w_mem_op && !reg_write) begin
                    pc_load  = 1'b1;
                    w_retire = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ack && !reg_write) begin
                    pc_load  = 1'b1;
                    w_retire = 1'b1;
                end
            end
            ST_WB: begin
                reg_we   = 1'b1;
                pc_load  = 1'b1;
                w_retire = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (r_state != ST_IDLE) && (r_state != ST_TRAP);
    assign trap       = (r_state == ST_TRAP);
    assign trap_cause = r_cause;
    assign retired    = r_retired;
    assign state      = r_state;

endmodule
